// File: rtl/imem_prog_loader.sv
// Program loader and run controller for the RV32i core: packs a byte stream into
// instruction memory words while the core is held in reset, then runs it until halt or timeout.
module imem_prog_loader #(
  parameter int         ADDR_WIDTH  = 8,
  parameter logic [6:0] HALT_OPCODE = 7'b1111111,
  parameter int         RST_CYCLES  = 2,
  parameter int         MAX_CYCLES  = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic                  load_end,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  input  logic [6:0]            ifid_opcode,
  output logic                  cpu_rst,
  output logic                  cpu_enable,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [31:0]           run_cycles,
  output logic                  halted,
  output logic                  timeout,
  output logic                  overflow
);

  localparam int REL_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RELEASE, S_RUN, S_HALT, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [REL_W-1:0]  rel_cnt_q, rel_cnt_d;

  logic                  byte_ready_d, imem_we_d, cpu_rst_d, cpu_enable_d;
  logic [ADDR_WIDTH-1:0] imem_addr_d;
  logic [31:0]           imem_wdata_d, run_cycles_d;
  logic [ADDR_WIDTH:0]   word_count_d;
  logic                  halted_d, timeout_d, overflow_d;

  logic        accept, write_req, ovf, budget_hit;
  logic [31:0] asm_merged;

  // The byte taken on this edge is merged before a full word or load_end is acted on.
  always_comb begin
    accept     = (state_q == S_LOAD) && byte_valid && byte_ready;
    asm_merged = {8'h00, asm_q};
    if (accept) asm_merged[{byte_idx_q, 3'b000} +: 8] = byte_in;
    write_req  = (accept && (byte_idx_q == 2'd3)) ||
                 (load_end && (accept || (byte_idx_q != 2'd0)));
    // Capacity is exhausted exactly when the top bit of word_count is set.
    ovf        = write_req && word_count[ADDR_WIDTH];
    budget_hit = (MAX_CYCLES != 0) && (run_cycles == 32'(MAX_CYCLES - 1));
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    rel_cnt_d    = rel_cnt_q;
    byte_ready_d = 1'b0;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    cpu_rst_d    = cpu_rst;
    cpu_enable_d = cpu_enable;
    word_count_d = word_count;
    run_cycles_d = run_cycles;
    halted_d     = halted;
    timeout_d    = timeout;
    overflow_d   = overflow;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (load_start) begin
          state_d      = S_LOAD;
          byte_ready_d = 1'b1;
          cpu_rst_d    = 1'b1;
          cpu_enable_d = 1'b0;
          byte_idx_d   = 2'd0;
          asm_d        = 24'h0;
          word_count_d = '0;
          run_cycles_d = 32'h0;
          halted_d     = 1'b0;
          timeout_d    = 1'b0;
          overflow_d   = 1'b0;
        end
      end

      S_LOAD: begin
        byte_ready_d = 1'b1;
        if (write_req) begin
          byte_idx_d = 2'd0;
          asm_d      = 24'h0;
          if (!ovf) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_count[ADDR_WIDTH-1:0];
            imem_wdata_d = asm_merged;
            word_count_d = word_count + 1'b1;
          end
        end else if (accept) begin
          byte_idx_d = byte_idx_q + 2'd1;
          asm_d      = asm_merged[23:0];
        end
        if (ovf) begin
          state_d      = S_ERROR;
          byte_ready_d = 1'b0;
          overflow_d   = 1'b1;
        end else if (load_end) begin
          state_d      = S_RELEASE;
          byte_ready_d = 1'b0;
          rel_cnt_d    = '0;
        end
      end

      S_RELEASE: begin
        if (rel_cnt_q == REL_W'(RST_CYCLES - 1)) begin
          state_d      = S_RUN;
          cpu_rst_d    = 1'b0;
          cpu_enable_d = 1'b1;
        end else begin
          rel_cnt_d = rel_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        run_cycles_d = run_cycles + 32'd1;
        if (ifid_opcode == HALT_OPCODE) begin
          state_d      = S_HALT;
          cpu_enable_d = 1'b0;
          halted_d     = 1'b1;
        end else if (budget_hit) begin
          state_d      = S_HALT;
          cpu_enable_d = 1'b0;
          timeout_d    = 1'b1;
        end
      end

      S_ERROR: begin
        cpu_rst_d    = 1'b1;
        cpu_enable_d = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      byte_idx_q <= 2'd0;
      asm_q      <= 24'h0;
      rel_cnt_q  <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
      cpu_rst    <= 1'b1;
      cpu_enable <= 1'b0;
      word_count <= '0;
      run_cycles <= 32'h0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      rel_cnt_q  <= rel_cnt_d;
      byte_ready <= byte_ready_d;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      cpu_rst    <= cpu_rst_d;
      cpu_enable <= cpu_enable_d;
      word_count <= word_count_d;
      run_cycles <= run_cycles_d;
      halted     <= halted_d;
      timeout    <= timeout_d;
      overflow   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Bench for imem_prog_loader: a large-memory and a 4-word instance share one stimulus stream;
// expected words, write counts and run/halt outcomes come from a byte-list model.
module tb_imem_prog_loader;

  localparam int TB_MAX = 10;
  localparam int TB_RST = 2;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start, byte_valid, load_end;
  logic [7:0] byte_in;
  logic [6:0] ifid_opcode;

  logic        b_ready, b_we, b_cpu_rst, b_en, b_halted, b_timeout, b_ovf;
  logic [7:0]  b_addr;
  logic [8:0]  b_wc;
  logic [31:0] b_wdata, b_rc;

  logic        s_ready, s_we, s_cpu_rst, s_en, s_halted, s_timeout, s_ovf;
  logic [1:0]  s_addr;
  logic [2:0]  s_wc;
  logic [31:0] s_wdata, s_rc;

  int checks = 0;
  int errors = 0;
  logic [63:0] wq_b[$];
  logic [63:0] wq_s[$];

  always #5 clk = ~clk;

  imem_prog_loader #(.ADDR_WIDTH(8), .RST_CYCLES(TB_RST), .MAX_CYCLES(TB_MAX)) u_big (
    .clk(clk), .rst(rst), .load_start(load_start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(b_ready), .load_end(load_end),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata), .ifid_opcode(ifid_opcode),
    .cpu_rst(b_cpu_rst), .cpu_enable(b_en), .word_count(b_wc), .run_cycles(b_rc),
    .halted(b_halted), .timeout(b_timeout), .overflow(b_ovf)
  );

  imem_prog_loader #(.ADDR_WIDTH(2), .RST_CYCLES(TB_RST), .MAX_CYCLES(TB_MAX)) u_small (
    .clk(clk), .rst(rst), .load_start(load_start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(s_ready), .load_end(load_end),
    .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata), .ifid_opcode(ifid_opcode),
    .cpu_rst(s_cpu_rst), .cpu_enable(s_en), .word_count(s_wc), .run_cycles(s_rc),
    .halted(s_halted), .timeout(s_timeout), .overflow(s_ovf)
  );

  // Write monitor: every strobed word, as {address, data}.
  always @(negedge clk) begin
    if (b_we === 1'b1) wq_b.push_back({32'(b_addr), b_wdata});
    if (s_we === 1'b1) wq_s.push_back({32'(s_addr), s_wdata});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check2(input string tag, input logic [63:0] ob, input logic [63:0] os,
                        input logic [63:0] exp);
    check({tag, ".big"}, ob, exp);
    check({tag, ".small"}, os, exp);
  endtask

  task automatic check_reset(input string tag);
    check2({tag, ".byte_ready"}, b_ready, s_ready, 0);
    check2({tag, ".imem_we"}, b_we, s_we, 0);
    check2({tag, ".imem_addr"}, b_addr, s_addr, 0);
    check2({tag, ".imem_wdata"}, b_wdata, s_wdata, 0);
    check2({tag, ".cpu_rst"}, b_cpu_rst, s_cpu_rst, 1);
    check2({tag, ".cpu_enable"}, b_en, s_en, 0);
    check2({tag, ".word_count"}, b_wc, s_wc, 0);
    check2({tag, ".run_cycles"}, b_rc, s_rc, 0);
    check2({tag, ".halted"}, b_halted, s_halted, 0);
    check2({tag, ".timeout"}, b_timeout, s_timeout, 0);
    check2({tag, ".overflow"}, b_ovf, s_ovf, 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Idle cycles with byte_valid low and junk on byte_in that must never be taken.
  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) begin
      byte_in = 8'($urandom);
      cycle();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic with_end);
    int waited = 0;
    byte_valid = 1'b1;
    byte_in    = b;
    load_end   = with_end;
    while (b_ready !== 1'b1 && waited < 20) begin
      cycle();
      waited++;
    end
    if (waited >= 20) check("byte_ready_wait", b_ready, 1);
    cycle();
    byte_valid = 1'b0;
    load_end   = 1'b0;
  endtask

  task automatic pulse_start(input bit garbage);
    if (garbage) begin
      byte_valid = 1'b1;
      byte_in    = 8'hEE;
      repeat (2) cycle();
    end
    load_start = 1'b1;
    cycle();
    load_start = 1'b0;
  endtask

  // Full load + run; model packs bytes little-endian into zero-padded words and
  // derives the stop cycle from the halt position and the budget.
  task automatic run_load(input string tag, input byte_q_t bytes, input bit end_with_last,
                          input bit garbage, input int halt_at);
    logic [31:0] words[$];
    logic [31:0] w = 32'h0;
    int  n = bytes.size();
    bit  end_on_byte = end_with_last && (n > 0);
    bit  exp_we0;
    bit  exp_h;
    int  exp_rc;
    int  i = 0;

    for (int k = 0; k < n; k++) begin
      w = w | (32'(bytes[k]) << (8 * (k % 4)));
      if ((k % 4 == 3) || (k == n - 1)) begin
        words.push_back(w);
        w = 32'h0;
      end
    end
    exp_we0 = end_on_byte || (n % 4 != 0);
    exp_h   = (halt_at >= 0) && (halt_at < TB_MAX);
    exp_rc  = exp_h ? halt_at + 1 : TB_MAX;

    wq_b.delete();
    wq_s.delete();
    pulse_start(garbage);
    check2({tag, ".load_ready"}, b_ready, s_ready, 1);
    check2({tag, ".load_cpu_rst"}, b_cpu_rst, s_cpu_rst, 1);

    for (int k = 0; k < n; k++) begin
      if (k > 0) idle($urandom_range(0, 2));
      send_byte(bytes[k], end_on_byte && (k == n - 1));
    end
    if (!end_on_byte) begin
      idle($urandom_range(0, 1));
      load_end = 1'b1;
      cycle();
      load_end = 1'b0;
    end

    // One cycle into RELEASE: final write strobe (if any), core still in reset.
    check2({tag, ".end_we"}, b_we, s_we, exp_we0);
    check2({tag, ".end_ready"}, b_ready, s_ready, 0);
    check2({tag, ".rel_cpu_rst1"}, b_cpu_rst, s_cpu_rst, 1);
    cycle();
    check2({tag, ".we_one_cycle"}, b_we, s_we, 0);
    check2({tag, ".rel_cpu_rst2"}, b_cpu_rst, s_cpu_rst, 1);
    cycle();
    check2({tag, ".run_cpu_rst"}, b_cpu_rst, s_cpu_rst, 0);
    check2({tag, ".run_enable"}, b_en, s_en, 1);

    check2({tag, ".word_count"}, b_wc, s_wc, words.size());
    check2({tag, ".n_writes"}, wq_b.size(), wq_s.size(), words.size());
    for (int k = 0; k < words.size() && k < wq_b.size() && k < wq_s.size(); k++)
      check2($sformatf("%s.write%0d", tag, k), wq_b[k], wq_s[k], {32'(k), words[k]});

    while (b_en === 1'b1 && i < 200) begin
      ifid_opcode = (i == halt_at) ? 7'h7F : 7'($urandom_range(0, 126));
      cycle();
      i++;
    end
    ifid_opcode = 7'h0;
    check({tag, ".stop_cycle"}, i, exp_rc);
    check2({tag, ".halted"}, b_halted, s_halted, exp_h);
    check2({tag, ".timeout"}, b_timeout, s_timeout, !exp_h);
    check2({tag, ".run_cycles"}, b_rc, s_rc, exp_rc);
    check2({tag, ".halt_enable"}, b_en, s_en, 0);
    check2({tag, ".halt_cpu_rst"}, b_cpu_rst, s_cpu_rst, 0);
    idle(3);
    check2({tag, ".run_cycles_frozen"}, b_rc, s_rc, exp_rc);
  endtask

  initial begin
    byte_q_t bq;
    logic [31:0] exp_w;

    rst = 1'b0;
    load_start = 1'b0;
    byte_valid = 1'b0;
    load_end = 1'b0;
    byte_in = 8'h0;
    ifid_opcode = 7'h0;
    repeat (2) @(negedge clk);
    check_reset("por");
    rst = 1'b1;
    idle(2);
    check2("idle.byte_ready", b_ready, s_ready, 0);

    bq = '{8'h13, 8'h05, 8'hA0, 8'h00};
    run_load("t1_timeout", bq, 1'b1, 1'b0, -1);

    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_load("t2_halt5", bq, 1'b0, 1'b0, 5);

    bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h42};
    run_load("t3_garbage_halt9", bq, 1'b0, 1'b1, 9);

    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load("t4_halt0", bq, 1'b0, 1'b0, 0);

    for (int it = 0; it < 8; it++) begin
      bq.delete();
      repeat ($urandom_range(0, 16)) bq.push_back(8'($urandom));
      run_load($sformatf("rnd%0d", it), bq, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 13)) - 1);
    end

    // Overflow: 20 bytes fill the 4-word instance and overflow on the fifth word.
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    wq_b.delete();
    wq_s.delete();
    pulse_start(1'b0);
    bq.delete();
    for (int k = 0; k < 20; k++) begin
      bq.push_back(8'($urandom));
      send_byte(bq[k], 1'b0);
    end
    check("ovf.flag.small", s_ovf, 1);
    check("ovf.ready.small", s_ready, 0);
    check("ovf.cpu_rst.small", s_cpu_rst, 1);
    check("ovf.enable.small", s_en, 0);
    check("ovf.word_count.small", s_wc, 4);
    check("ovf.flag.big", b_ovf, 0);
    check("ovf.ready.big", b_ready, 1);
    idle(2);
    check("ovf.n_writes.small", wq_s.size(), 4);
    check("ovf.n_writes.big", wq_b.size(), 5);
    check("ovf.word_count.big", b_wc, 5);
    for (int k = 0; k < 4 && k < wq_s.size(); k++) begin
      exp_w = {bq[4*k+3], bq[4*k+2], bq[4*k+1], bq[4*k]};
      check($sformatf("ovf.write%0d.small", k), wq_s[k], {32'(k), exp_w});
    end
    pulse_start(1'b0);
    idle(1);
    check("error_sticky.ready.small", s_ready, 0);
    check("error_sticky.flag.small", s_ovf, 1);
    check("error_sticky.we.small", s_we, 0);
    check("start_ignored.word_count.big", b_wc, 5);

    // Reset in the middle of a load: partial word is dropped, all outputs return to reset.
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    wq_b.delete();
    wq_s.delete();
    pulse_start(1'b0);
    for (int k = 0; k < 6; k++) send_byte(8'($urandom), 1'b0);
    check2("midrst.pre_writes", wq_b.size(), wq_s.size(), 1);
    byte_valid = 1'b1;
    #2 rst = 1'b0;
    #1 check_reset("midrst.async");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(3);
    check_reset("midrst.idle");
    check2("midrst.no_write", wq_b.size(), wq_s.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
